// File: rtl/tensor_core_pkg.sv
// Shared state type and width helpers for the register stream reader.
package tensor_core_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StFinish
  } reader_state_e;

  localparam int unsigned DefaultNumberOfRegisters = 8;
  localparam int unsigned DefaultDataWidth         = 8;

  // A single-entry register file still needs one address bit.
  function automatic int unsigned reader_addr_width(input int unsigned number_of_registers);
    return (number_of_registers > 1) ? $clog2(number_of_registers) : 1;
  endfunction

  // One extra bit so a full-depth burst length is representable.
  function automatic int unsigned reader_count_width(input int unsigned number_of_registers);
    return reader_addr_width(number_of_registers) + 1;
  endfunction

endpackage

// File: rtl/stream_output_register.sv
// Registered stream beat (data, last, valid) that holds its contents while the sink stalls.
module stream_output_register #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  clear_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/register_stream_reader.sv
// Reads a burst of consecutive registers (wrapping at the top) and emits them as a
// valid/ready stream with a last marker and a done pulse.
module register_stream_reader
  import tensor_core_pkg::*;
#(
  parameter int unsigned  NUMBER_OF_REGISTERS = DefaultNumberOfRegisters,
  parameter int unsigned  DATA_WIDTH          = DefaultDataWidth,
  localparam int unsigned AddrWidth           = reader_addr_width(NUMBER_OF_REGISTERS),
  localparam int unsigned CountWidth          = reader_count_width(NUMBER_OF_REGISTERS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AddrWidth-1:0]  start_address,
  input  logic [CountWidth-1:0] burst_length,
  output logic                  rf_enable,
  output logic [AddrWidth-1:0]  rf_address,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  reader_state_e         state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  load;
  logic                  load_last;
  logic                  clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    rf_enable = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    clear     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          if (burst_length != '0) begin
            addr_d  = start_address;
            count_d = burst_length;
            state_d = StRead;
          end else begin
            state_d = StFinish;
          end
        end
      end

      StRead: begin
        rf_enable = 1'b1;
        // Refill whenever the held beat is empty or leaving this edge.
        load      = !out_valid || out_ready;
        load_last = (count_q == CountWidth'(1));
        if (load) begin
          addr_d  = (addr_q == AddrWidth'(NUMBER_OF_REGISTERS - 1)) ? '0 : addr_q + 1'b1;
          count_d = count_q - 1'b1;
          if (load_last) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (out_ready) begin
          clear   = 1'b1;
          state_d = StFinish;
        end
      end

      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign rf_address = addr_q;

  stream_output_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_output_register (
    .clock  (clock),
    .reset  (reset),
    .load_i (load),
    .data_i (rf_read_data),
    .last_i (load_last),
    .clear_i(clear),
    .valid_o(out_valid),
    .data_o (out_data),
    .last_o (out_last)
  );

endmodule

// File: tb/tb_register_stream_reader.sv
// Self-checking bench for register_stream_reader: directed table, corner sequences, random bursts.
module tb_register_stream_reader;

  localparam int NREG = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] start_address;
  logic [3:0] burst_length;
  logic       rf_enable;
  logic [2:0] rf_address;
  logic [7:0] rf_read_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] regs [NREG];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign rf_read_data = regs[rf_address];

  register_stream_reader #(
    .NUMBER_OF_REGISTERS(NREG),
    .DATA_WIDTH         (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .start_address(start_address),
    .burst_length (burst_length),
    .rf_enable    (rf_enable),
    .rf_address   (rf_address),
    .rf_read_data (rf_read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one burst starting at the current negedge and checks it against a queue of the
  // expected register values. Returns at the negedge of the cycle after done (idle again).
  // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic run_burst(input int sa, input int len, input int mode, input bit poke,
                           input bit chk_ends, input logic [7:0] exp_first,
                           input logic [7:0] exp_last);
    logic [7:0] exp_q[$];
    logic [3:0] pat;
    logic [7:0] prev_data;
    int         k, c, due;
    bit         prev_valid, prev_ready, prev_last, finished, r, exp_en;
    pat = 4'b1001;
    for (int i = 0; i < len; i++) exp_q.push_back(regs[(sa + i) % NREG]);
    start         = 1'b1;
    start_address = 3'(sa);
    burst_length  = 4'(len);
    out_ready     = 1'b1;
    k = 0;
    c = 0;
    due = (len == 0) ? 1 : -1;
    prev_valid = 0;
    prev_ready = 0;
    prev_last  = 0;
    prev_data  = '0;
    finished   = 0;
    while (!finished && c < 200) begin
      @(negedge clock);
      c++;
      start = 1'b0;
      if (due >= 0 && c == due + 1) begin
        check("done_clears", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_no_valid", out_valid, 0);
        finished = 1;
      end else begin
        if (poke && c == 3) begin
          start         = 1'b1;
          start_address = 3'd0;
          burst_length  = 4'd1;
        end
        check("done_timing", done, (c == due));
        check("busy_in_burst", busy, 1);
        if (c == due) begin
          check("beat_count", k, len);
          check("valid_after_last", out_valid, 0);
        end
        if (prev_valid && !prev_ready) begin
          check("stall_valid_held", out_valid, 1);
          check("stall_data_held", out_data, prev_data);
          check("stall_last_held", out_last, prev_last);
        end
        if (c == 1) check("no_early_beat", out_valid, 0);
        if (c == 2 && len > 0) check("first_beat_latency", out_valid, 1);
        if (mode == 0 && len > 0 && c >= 2 && c < len + 2) check("no_bubble", out_valid, 1);
        exp_en = (c != due) && (k + int'(out_valid) < len);
        check("rf_enable", rf_enable, exp_en);
        if (exp_en) check("rf_address", rf_address, (sa + k + int'(out_valid)) % NREG);
        if (out_valid) check("out_last", out_last, (k == len - 1));
        case (mode)
          0:       r = 1'b1;
          1:       r = pat[(c - 1) % 4];
          default: r = ($urandom_range(0, 3) != 0);
        endcase
        out_ready = r;
        if (out_valid && r) begin
          if (k < len) begin
            check("beat_data", out_data, exp_q[k]);
            if (chk_ends && k == 0) check("first_beat_value", out_data, exp_first);
            if (chk_ends && k == len - 1) check("last_beat_value", out_data, exp_last);
            if (k == len - 1) due = c + 1;
          end else begin
            check("extra_beat", k, len - 1);
          end
          k++;
        end
        prev_valid = out_valid;
        prev_ready = r;
        prev_last  = out_last;
        prev_data  = out_data;
      end
    end
    if (!finished) check("burst_timeout", c, -1);
  endtask

  typedef struct {
    int         sa;
    int         len;
    int         mode;
    bit         poke;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{sa: 2, len: 3, mode: 0, poke: 0, first: 8'h12, last: 8'h14};
    vecs[1] = '{sa: 6, len: 4, mode: 0, poke: 0, first: 8'h16, last: 8'h11};
    vecs[2] = '{sa: 1, len: 3, mode: 1, poke: 0, first: 8'h11, last: 8'h13};
    vecs[3] = '{sa: 0, len: 0, mode: 0, poke: 0, first: 8'h00, last: 8'h00};
    vecs[4] = '{sa: 1, len: 5, mode: 0, poke: 1, first: 8'h11, last: 8'h15};
    vecs[5] = '{sa: 5, len: 8, mode: 1, poke: 0, first: 8'h15, last: 8'h14};
    vecs[6] = '{sa: 7, len: 1, mode: 2, poke: 0, first: 8'h17, last: 8'h17};

    for (int i = 0; i < NREG; i++) regs[i] = 8'(8'h10 + i);
    reset         = 1'b1;
    start         = 1'b0;
    start_address = '0;
    burst_length  = '0;
    out_ready     = 1'b0;

    repeat (2) @(negedge clock);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_rf_enable", rf_enable, 0);
    check("reset_rf_address", rf_address, 0);
    check("reset_out_data", out_data, 0);
    reset = 1'b0;

    // Back-to-back bursts: each new start lands in the cycle right after done.
    for (int i = 0; i < 7; i++)
      run_burst(vecs[i].sa, vecs[i].len, vecs[i].mode, vecs[i].poke, 1'b1,
                vecs[i].first, vecs[i].last);

    // Reset after the second beat of an 8-beat burst drops the burst silently.
    @(negedge clock);
    start = 1'b1; start_address = 3'd0; burst_length = 4'd8; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("rst_seq_beat0", out_data, 8'h10);
    @(negedge clock);
    check("rst_seq_beat1", out_data, 8'h11);
    @(negedge clock);
    check("rst_seq_beat2_valid", out_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_rf_enable", rf_enable, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_out_last", out_last, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_no_done", done, 0);
      check("rst_stays_idle", busy, 0);
    end
    run_burst(0, 1, 0, 0, 1'b1, 8'h10, 8'h10);

    // Reset wins over a start in the same cycle.
    reset = 1'b1; start = 1'b1; start_address = 3'd3; burst_length = 4'd2;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("rst_over_start_busy", busy, 0);
    @(negedge clock);
    check("rst_over_start_idle", busy, 0);
    check("rst_over_start_valid", out_valid, 0);

    // Random register contents, bursts, backpressure and idle gaps.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_burst($urandom_range(0, NREG - 1), $urandom_range(0, NREG), 2,
                ($urandom_range(0, 1) == 1), 1'b0, 8'h00, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
